// File: rtl/core_pkg.sv
// Shared encodings for the core-side memory access path: store sizes, load kinds, FSM states.
package core_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_LOAD = 2'b11
  } store_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  // 0 = byte, 1 = half, 2 = word; undefined load kinds behave as LW
  function automatic logic [1:0] access_width(input logic [1:0] size, input logic [2:0] funct3);
    if (size != SZ_LOAD) return size;
    case (funct3)
      F3_LB, F3_LBU: return 2'd0;
      F3_LH, F3_LHU: return 2'd1;
      default:       return 2'd2;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] funct3,
                                         input logic [1:0] offset);
    logic [1:0] width;
    width = access_width(size, funct3);
    return ((width == 2'd1) && offset[0]) || ((width == 2'd2) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core request/response and memory-bus signals of the access unit, bundled with both-side views.
interface mem_access_if;
  logic        memory_en;
  logic [1:0]  store_size;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output memory_en, store_size, funct3, addr, wdata, mem_ack, mem_rdata,
    input  stall, rdata, rdata_valid, misaligned, mem_req, mem_we, mem_addr, mem_wmask, mem_wdata
  );

  modport slave (
    input  memory_en, store_size, funct3, addr, wdata, mem_ack, mem_rdata,
    output stall, rdata, rdata_valid, misaligned, mem_req, mem_we, mem_addr, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it by load kind.
module load_align
  import core_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  kind_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = word_i >> {offset_i, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = shifted[15:0];
    case (kind_i)
      F3_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result_o = {24'h0, byte_sel};
      F3_LHU:  result_o = {16'h0, half_sel};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the core and a word-addressed memory with an ack handshake.
// state | meaning
// IDLE  | waiting for memory_en; checks alignment
// REQ   | mem_req held with stable address/mask/data until mem_ack
// DONE  | one cycle; rdata_valid pulses for loads
// ERR   | one cycle; misaligned pulses, no memory traffic
module mem_access_unit
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  mem_access_if.slave  bus
);

  state_e      state_q;
  logic        mem_req_q, mem_we_q, rdata_valid_q, misaligned_q, is_load_q;
  logic [29:0] mem_addr_q;
  logic [3:0]  mem_wmask_q, wmask_d;
  logic [31:0] mem_wdata_q, wdata_d, rdata_q, load_result;
  logic [2:0]  kind_q;
  logic [1:0]  offset_q;
  logic        misaligned_d;

  always_comb begin
    wmask_d = 4'b0000;
    wdata_d = bus.wdata;
    case (bus.store_size)
      SZ_BYTE: begin
        wmask_d = 4'b0001 << bus.addr[1:0];
        wdata_d = {4{bus.wdata[7:0]}};
      end
      SZ_HALF: begin
        wmask_d = 4'b0011 << bus.addr[1:0];
        wdata_d = {2{bus.wdata[15:0]}};
      end
      SZ_WORD: wmask_d = 4'b1111;
      default: ;
    endcase
  end

  assign misaligned_d = is_misaligned(bus.store_size, bus.funct3, bus.addr[1:0]);

  load_align u_load_align (
    .word_i   (bus.mem_rdata),
    .offset_i (offset_q),
    .kind_i   (kind_q),
    .result_o (load_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wmask_q   <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      is_load_q     <= 1'b0;
      kind_q        <= '0;
      offset_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.memory_en) begin
            if (misaligned_d) begin
              state_q      <= S_ERR;
              misaligned_q <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= (bus.store_size != SZ_LOAD);
              is_load_q   <= (bus.store_size == SZ_LOAD);
              mem_addr_q  <= bus.addr[31:2];
              mem_wmask_q <= wmask_d;
              mem_wdata_q <= wdata_d;
              kind_q      <= bus.funct3;
              offset_q    <= bus.addr[1:0];
            end
          end
        end
        S_REQ: begin
          if (bus.mem_ack) begin
            state_q     <= S_DONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= 4'b0000;
            if (is_load_q) begin
              rdata_q       <= load_result;
              rdata_valid_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          rdata_valid_q <= 1'b0;
          state_q       <= S_IDLE;
        end
        S_ERR: begin
          misaligned_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stall reacts to memory_en in the same cycle so the core freezes before acceptance.
  assign bus.stall       = ((state_q == S_IDLE) && bus.memory_en) || (state_q == S_REQ);
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wmask   = mem_wmask_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.misaligned  = misaligned_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: CLK in 1, rising-edge clock; RST_N in 1, asynchronous active-low reset.
REQ-002 memory_en  in  1  core requests a memory access this cycle.
REQ-003 store_size  in  2  00 = byte store, 01 = half store, 10 = word store, 11 = load.
REQ-004 funct3  in  3  load kind: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 SHALL be treated as LW.
REQ-005 addr  in  32  byte address; wdata  in  32  store data, right-aligned.
REQ-006 stall  out  1  core SHALL hold its inputs while stall=1.
REQ-007 rdata  out  32  extended load result; rdata_valid  out  1  one-cycle strobe.
REQ-008 misaligned  out  1  one-cycle strobe for a rejected misaligned access.
REQ-009 mem_req  out  1; mem_we  out  1; mem_addr  out  30 (word address); mem_wmask  out  4; mem_wdata  out  32.
REQ-010 mem_ack  in  1  memory completes the request; mem_rdata  in  32  read word, valid with mem_ack.

Function
REQ-011 FSM states SHALL be IDLE, REQ, DONE, ERR.
REQ-012 Accept in IDLE: memory_en=1 and the access is aligned. The unit SHALL then register addr[31:2], mask, lane-shifted data, load kind and addr[1:0], and go to REQ.
REQ-013 stall SHALL equal (IDLE & memory_en) | REQ. stall SHALL be 0 in DONE and ERR.
REQ-014 In REQ, mem_req SHALL be 1 with all mem_* outputs stable until the cycle mem_ack=1 is sampled. The FSM SHALL then go to DONE.
REQ-015 Masks: byte store = 0001 shifted left by addr[1:0]; half store = 0011 << addr[1:0]; word store = 1111; load: mem_we=0, mask=0000.
REQ-016 mem_wdata lanes: byte = wdata[7:0] replicated to all 4 lanes; half = wdata[15:0] replicated to both halves; word = wdata.
REQ-017 Load result SHALL be captured from mem_rdata on the mem_ack cycle. It is extracted by the registered addr[1:0], then sign-extended (LB/LH) or zero-extended (LBU/LHU).
REQ-018 DONE SHALL last exactly one cycle. It SHALL assert rdata_valid=1 for loads and 0 for stores, and then return to IDLE.
REQ-019 memory_en seen in DONE or ERR SHALL be ignored; the next request SHALL be accepted no earlier than the following IDLE cycle.
REQ-020 Misaligned cases: half access with addr[0]=1, or word access with addr[1:0]≠00. In these cases the FSM SHALL go IDLE→ERR with no mem_req, pulse misaligned=1 in ERR, and return to IDLE.
REQ-021 Minimum latency SHALL be accept→REQ (1)→DONE (2) when mem_ack arrives in the first REQ cycle. There is no upper bound; mem_req SHALL be held indefinitely.
REQ-022 mem_ack sampled outside REQ SHALL be ignored.
REQ-023 rdata SHALL hold its last value between loads.

Reset
REQ-024 While RST_N=0 the state SHALL be IDLE, and mem_req, mem_we, mem_wmask, rdata_valid and misaligned SHALL be 0. rdata, mem_addr and mem_wdata SHALL be 0.
REQ-025 Reset asserted mid-REQ SHALL drop mem_req immediately (asynchronously); the pending access is abandoned.
REQ-026 After RST_N deasserts, the first request SHALL be accepted on the first rising edge with memory_en=1.

Structure
REQ-027 A shared package core_pkg SHALL hold: the store_size encodings, the load funct3 codes, and the FSM state enum.
REQ-028 Byte extraction and extension SHALL be a combinational sub-module load_align (inputs: word, offset, kind; output: 32-bit result).

Verification
REQ-029 SB: addr=0x103, wdata=0xAB → mem_addr=0x40, wmask=1000, wdata lanes=0xABABABAB, mem_we=1; ack at first REQ cycle → stall high for 2 cycles.
REQ-030 LB: addr=0x2, mem_rdata=0x00800000 → rdata=0xFFFFFF80 with rdata_valid=1 for 1 cycle. LBU with the same stimulus → rdata=0x00000080.
REQ-031 LW: addr=0x4, ack delayed 5 cycles → mem_req held 5 cycles with stable outputs, stall=1 throughout, rdata=mem_rdata.
REQ-032 SW: addr=0x6 → no mem_req, misaligned=1 for one cycle; stall high for the request cycle only.
REQ-033 RST_N pulled low during REQ → mem_req=0 in the same cycle. After release, an LH at addr=0x2 with mem_rdata=0x7FFF0000 → rdata=0x00007FFF.
REQ-034 Back-to-back: memory_en held high through DONE → exactly one access is issued per instruction, and the next access starts from IDLE.
